// File: rtl/fp_add_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// fp_add_ctrl
//
// Issue/retire sequencer wrapped around the 32-bit floating-point adder
// (fp_add). One operand pair is accepted over a valid/ready handshake. The
// pair and its rounding mode are registered onto the adder inputs and held
// there for the adder's full pipeline depth. This matters because the adder's
// second stage still reads combinational terms of its inputs. After LAT + 1
// edges the adder result is captured into a valid/ready output buffer. Its
// IEEE exception flags are OR-ed into a sticky status register, which software
// clears.
//
// At most one operation is in flight. In DONE, a consumed result and a new
// accept may share the same edge, which gives one operation per LAT + 2 cycles.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-low reset
//   in_valid     operand pair offered
//   in_ready     operand pair accepted when in_valid && in_ready at posedge
//   in_a, in_b   operands
//   in_rm        rounding mode, passed through unchecked
//   add_in1/2    registered operands to fp_add
//   add_round_m  registered rounding mode to fp_add
//   add_act      fp_add activity enable; high while an operation is in flight
//   add_out      fp_add sum
//   add_ov/un/inv/inexact  fp_add exception flags
//   res_valid    captured result available
//   res_ready    result consumed when res_valid && res_ready at posedge
//   res_out      captured sum
//   res_flags    {inv, ov, un, inexact} of the captured result
//   fflags       sticky {inv, ov, un, inexact}
//   fflags_clr   synchronous clear of fflags
//   busy         sequencer not idle
// -----------------------------------------------------------------------------
module fp_add_ctrl #(
    parameter int W   = 32,  // operand/result width
    parameter int LAT = 2,   // adder latency, stable inputs to registered output
    parameter int CW  = 2    // latency counter width; must be able to hold LAT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_rm,

    output logic [W-1:0] add_in1,
    output logic [W-1:0] add_in2,
    output logic [2:0]   add_round_m,
    output logic         add_act,
    input  logic [W-1:0] add_out,
    input  logic         add_ov,
    input  logic         add_un,
    input  logic         add_inv,
    input  logic         add_inexact,

    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_out,
    output logic [3:0]   res_flags,

    output logic [3:0]   fflags,
    input  logic         fflags_clr,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for operands
        BUSY = 2'd1,  // adder inputs held, counting down the pipeline
        DONE = 2'd2   // result buffered, waiting to be consumed
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   in1_q;
    logic [W-1:0]   in2_q;
    logic [2:0]     rm_q;
    logic           act_q;
    logic           res_valid_q;
    logic [W-1:0]   res_out_q;
    logic [3:0]     res_flags_q;
    logic [3:0]     fflags_q;
    logic [3:0]     fflags_d;

    logic           accept;
    logic           capture;
    logic [3:0]     add_flags;

    // In DONE the buffer can take a new operand pair only on the edge that
    // also hands the current result over. So readiness follows res_ready.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so
        // no latch is inferred when a state is left out.
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = res_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    // The counter is loaded with LAT at accept and reaches zero LAT edges
    // later. The following edge samples the adder's registered output.
    assign capture   = (state_q == BUSY) && (cnt_q == '0);
    assign add_flags = {add_inv, add_ov, add_un, add_inexact};

    // A clear that coincides with a capture still keeps the new result's
    // flags. Only history older than the capture is dropped.
    assign fflags_d  = (fflags_clr ? 4'b0000 : fflags_q)
                     | (capture ? add_flags : 4'b0000);

    // NOTE: all state below uses non-blocking assignments. Every register
    // then sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            rm_q        <= '0;
            act_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_flags_q <= '0;
            fflags_q    <= '0;
        end else begin
            fflags_q <= fflags_d;

            if (accept) begin
                // Accept happens from IDLE or from DONE. From DONE it
                // also consumes the buffered result on the same edge.
                in1_q       <= in_a;
                in2_q       <= in_b;
                rm_q        <= in_rm;
                act_q       <= 1'b1;
                cnt_q       <= CW'(LAT);
                res_valid_q <= 1'b0;
                state_q     <= BUSY;
            end else begin
                case (state_q)
                    BUSY: begin
                        if (capture) begin
                            res_out_q   <= add_out;
                            res_flags_q <= add_flags;
                            res_valid_q <= 1'b1;
                            act_q       <= 1'b0;
                            state_q     <= DONE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    DONE: begin
                        // res_out/res_flags keep their value after
                        // consumption. Only the valid bit drops.
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        // IDLE without an accept: nothing changes. The adder
                        // inputs keep the last operands.
                    end
                endcase
            end
        end
    end

    assign add_in1     = in1_q;
    assign add_in2     = in2_q;
    assign add_round_m = rm_q;
    assign add_act     = act_q;
    assign res_valid   = res_valid_q;
    assign res_out     = res_out_q;
    assign res_flags   = res_flags_q;
    assign fflags      = fflags_q;

endmodule

// File: tb/tb_fp_add_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_fp_add_ctrl
//
// Bench for fp_add_ctrl. Contains:
//   - an adder stand-in with a two-stage pipeline. Its second stage re-reads
//     the live add_in2, so operands that move early corrupt the sum. For a few
//     operand pairs it returns the true IEEE single-precision sum and flags.
//     For any other pair it returns an arbitrary mix of the operands, because
//     the sequencer only transports the value.
//   - a transaction-level reference model. It tracks one op in flight, its
//     remaining edges, the buffered result and the sticky flags. It checks
//     every DUT output one time unit after each rising edge.
//   - directed scenarios with literal expectations, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_fp_add_ctrl;

    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int CW  = 2;

    localparam logic [2:0]  RNE     = 3'b000;
    localparam logic [31:0] ONE     = 32'h3F80_0000;
    localparam logic [31:0] TWO     = 32'h4000_0000;
    localparam logic [31:0] THREE   = 32'h4040_0000;
    localparam logic [31:0] PINF    = 32'h7F80_0000;
    localparam logic [31:0] NINF    = 32'hFF80_0000;
    localparam logic [31:0] TINY    = 32'h3080_0000;  // 2^-30
    localparam logic [31:0] FP_NANQ = 32'h7FC0_0000;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [2:0]     in_rm;
    logic [W-1:0]   add_in1;
    logic [W-1:0]   add_in2;
    logic [2:0]     add_round_m;
    logic           add_act;
    logic [W-1:0]   add_out;
    logic           add_ov;
    logic           add_un;
    logic           add_inv;
    logic           add_inexact;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_out;
    logic [3:0]     res_flags;
    logic [3:0]     fflags;
    logic           fflags_clr;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    fp_add_ctrl #(.W(W), .LAT(LAT), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rm       (in_rm),
        .add_in1     (add_in1),
        .add_in2     (add_in2),
        .add_round_m (add_round_m),
        .add_act     (add_act),
        .add_out     (add_out),
        .add_ov      (add_ov),
        .add_un      (add_un),
        .add_inv     (add_inv),
        .add_inexact (add_inexact),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_out     (res_out),
        .res_flags   (res_flags),
        .fflags      (fflags),
        .fflags_clr  (fflags_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Adder behaviour: returns {inv, ov, un, inexact, sum}.
    function automatic logic [35:0] fake_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] rm);
        logic [31:0] s;
        logic [3:0]  f;
        if      (a == ONE  && b == TWO)  begin s = THREE;   f = 4'b0000; end
        else if (a == ONE  && b == ONE)  begin s = TWO;     f = 4'b0000; end
        else if (a == PINF && b == NINF) begin s = FP_NANQ; f = 4'b1000; end
        else if (a == ONE  && b == TINY) begin s = ONE;     f = 4'b0001; end
        else begin
            s = (a ^ {b[15:0], b[31:16]}) + {29'd0, rm};
            f = a[3:0] ^ b[7:4] ^ {1'b0, rm};
        end
        return {f, s};
    endfunction

    // Adder stand-in: two pipeline stages that advance while add_act is high.
    logic [31:0] s1_a  = '0;
    logic [2:0]  s1_rm = '0;
    logic [35:0] s2    = '0;
    always @(posedge clk) begin
        if (add_act) begin
            s1_a  <= add_in1;
            s1_rm <= add_round_m;
            s2    <= fake_add(s1_a, add_in2, s1_rm);
        end
    end
    assign {add_inv, add_ov, add_un, add_inexact, add_out} = s2;

    // Transaction-level reference model.
    bit          m_flight = 0;   // operation inside the adder
    int          m_wait   = 0;   // edges left until the result is captured
    bit          m_have   = 0;   // buffered result not yet consumed
    logic [35:0] m_pend   = '0;  // expected {flags, sum} of the op in flight
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]  m_rm = '0;
    logic [3:0]  m_rflags = '0, m_ff = '0, m_cap = '0;
    bit          m_act = 0, m_acc = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_flight = 0; m_wait = 0; m_have = 0; m_act = 0;
            m_a = '0; m_b = '0; m_rm = '0; m_res = '0; m_rflags = '0; m_ff = '0;
        end else begin
            m_acc = in_valid && !m_flight && (!m_have || res_ready);
            m_cap = '0;
            if (m_flight) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_flight = 0;
                    m_have   = 1;
                    m_act    = 0;
                    {m_rflags, m_res} = m_pend;
                    m_cap    = m_pend[35:32];
                end
            end else if (m_have && res_ready) begin
                m_have = 0;
            end
            m_ff = (fflags_clr ? 4'b0000 : m_ff) | m_cap;
            if (m_acc) begin
                m_flight = 1;
                m_wait   = LAT + 1;
                m_pend   = fake_add(in_a, in_b, in_rm);
                m_a = in_a; m_b = in_b; m_rm = in_rm;
                m_act = 1;
            end
        end
        #1;
        check("in_ready",    in_ready,    !m_flight && (!m_have || res_ready));
        check("busy",        busy,        m_flight || m_have);
        check("add_in1",     add_in1,     m_a);
        check("add_in2",     add_in2,     m_b);
        check("add_round_m", add_round_m, m_rm);
        check("add_act",     add_act,     m_act);
        check("res_valid",   res_valid,   m_have);
        check("res_out",     res_out,     m_res);
        check("res_flags",   res_flags,   m_rflags);
        check("fflags",      fflags,      m_ff);
    end

    // Offers an operand pair from a falling edge. Returns on the falling edge
    // right after the accepting rising edge, with in_valid dropped.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         output int acc_cyc);
        bit done;
        int guard;
        done = 0; guard = 0;
        in_valid = 1; in_a = a; in_b = b; in_rm = rm;
        while (!done && guard < 50) begin
            #1 done = in_ready;
            @(negedge clk);
            guard++;
        end
        in_valid = 0;
        acc_cyc  = cyc;
        check("accept", done, 1);
    endtask

    // Counts rising edges after the accept until res_valid is seen.
    task automatic wait_res(output int edges);
        edges = 0;
        while (!res_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("result_timeout", res_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e, t, tp;
        logic [31:0] ra, rb;

        rst = 0; in_valid = 0; in_a = '0; in_b = '0; in_rm = '0;
        res_ready = 1; fflags_clr = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_add_act", add_act, 0);
        check("rst_fflags", fflags, 0);
        rst = 1;
        @(negedge clk);

        // 1.0 + 2.0: result exactly 3 edges after accept, no flags.
        issue(ONE, TWO, RNE, t);
        e = 0;
        while (!res_valid && e < 20) begin
            check("busy_in_ready_low", in_ready, 0);
            @(negedge clk);
            e++;
        end
        check("lat_1p2", e, 3);
        check("sum_1p2", res_out, THREE);
        check("flags_1p2", res_flags, 4'b0000);
        check("ff_1p2", fflags, 4'b0000);

        // +inf + -inf: invalid, quiet NaN, sticky invalid.
        issue(PINF, NINF, RNE, t);
        wait_res(e);
        check("sum_inf", res_out, FP_NANQ);
        check("flags_inf", res_flags, 4'b1000);
        check("ff_inf", fflags, 4'b1000);
        issue(ONE, ONE, RNE, t);
        wait_res(e);
        check("sum_1p1", res_out, TWO);
        check("ff_sticky", fflags, 4'b1000);
        fflags_clr = 1;
        @(negedge clk);
        fflags_clr = 0;
        check("ff_clear", fflags, 4'b0000);

        // Clear coinciding with the capture edge keeps only the new flags.
        issue(PINF, NINF, RNE, t);
        wait_res(e);
        issue(ONE, TINY, RNE, t);
        @(negedge clk);
        @(negedge clk);
        fflags_clr = 1;
        @(negedge clk);
        fflags_clr = 0;
        check("tiny_valid", res_valid, 1);
        check("sum_tiny", res_out, ONE);
        check("flags_tiny", res_flags, 4'b0001);
        check("ff_clr_capture", fflags, 4'b0001);

        // Backpressure: result held, no accept, then same-edge turnaround.
        @(negedge clk);
        res_ready = 0;
        issue(ONE, TWO, RNE, t);
        wait_res(e);
        check("lat_bp", e, 3);
        in_valid = 1; in_a = ONE; in_b = ONE; in_rm = RNE;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", res_valid, 1);
            check("bp_hold", res_out, THREE);
            check("bp_add_in2", add_in2, TWO);
            @(negedge clk);
        end
        res_ready = 1;
        issue(ONE, ONE, RNE, t);
        wait_res(e);
        check("lat_after_bp", e, 3);
        check("sum_after_bp", res_out, TWO);

        // Back-to-back stream: one operation every LAT + 2 cycles.
        tp = 0;
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            issue(ra, rb, 3'($urandom_range(0, 4)), t);
            if (i > 0) check("stream_spacing", t - tp, LAT + 2);
            tp = t;
        end
        wait_res(e);
        @(negedge clk);

        // Reset while an operation is in flight.
        issue(PINF, NINF, RNE, t);
        wait_res(e);
        issue(ONE, TWO, RNE, t);
        @(negedge clk);
        rst = 0;
        #1;
        check("rr_busy", busy, 0);
        check("rr_in_ready", in_ready, 1);
        check("rr_res_valid", res_valid, 0);
        check("rr_fflags", fflags, 0);
        check("rr_add_act", add_act, 0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_no_stale", res_valid, 0);
        end
        issue(ONE, ONE, RNE, t);
        wait_res(e);
        check("rr_lat", e, 3);
        check("rr_sum", res_out, TWO);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 799) != 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_a       = $urandom;
            in_b       = $urandom;
            in_rm      = 3'($urandom_range(0, 4));
            res_ready  = ($urandom_range(0, 9) < 6);
            fflags_clr = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        rst = 1; in_valid = 0; res_ready = 1; fflags_clr = 0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
